// File: rtl/fft_r22_stage_ctrl.sv
// rtl/fft_r22_stage_ctrl.sv - sequencer for one radix-2^2 SDF stage pair (BF2I + BF2II)
// Optional stall counter port enabled by FFT_R22_STAGE_CTRL_STALLCNT_EN.
module fft_r22_stage_ctrl #(
    parameter int LOG2N    = 6,
    parameter int ROM_LAT  = 1,
    parameter int PIPE_LAT = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             sof_in,
    input  logic             stop,
    output logic             stage_en,
    output logic             zero_in,
    output logic             s1,
    output logic             s2,
    output logic             t,
    output logic [LOG2N-1:0] rom_addr,
    output logic             out_valid,
    output logic             sof_out,
    output logic             frame_done,
    output logic             busy
`ifdef FFT_R22_STAGE_CTRL_STALLCNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    localparam int L        = LOG2N;
    localparam int N        = 1 << LOG2N;
    localparam int FILL_LEN = 3 * N / 4;
    localparam logic [L-1:0] FILL_C = L'(FILL_LEN);
    localparam logic [L-1:0] LAST_C = L'(FILL_LEN - 1);
    localparam logic [L-1:0] RL_C   = L'(ROM_LAT);
    localparam logic [L-1:0] CMAX   = L'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [L-1:0]        c_q, c_d;
    logic [L-1:0]        fill_q, fill_d;
    logic [L-1:0]        flush_q, flush_d;
    logic                flush_req_q, flush_req_d;
    logic                first_q, first_d;
    logic [L-1:0]        rom_addr_q, rom_addr_d;
    logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
    logic [PIPE_LAT-1:0] spipe_q, spipe_d;
    logic [PIPE_LAT-1:0] lpipe_q, lpipe_d;
    logic                frame_done_q, frame_done_d;
    logic                issue;
    logic [L-1:0]        c2;
    logic [L-1:0]        k_ext;
    logic [L-1:0]        m_ext;

    // c2 runs ROM_LAT ahead of the output index so the ROM data lines up;
    // quadrant multiplier {0,2,1,3} is just q with its bits swapped.
    assign c2    = c_q - FILL_C + RL_C;
    assign k_ext = {2'b00, c2[L-3:0]};
    assign m_ext = {{(L-2){1'b0}}, c2[L-2], c2[L-1]};

    always_comb begin
        stage_en = 1'b0;
        case (state_q)
            IDLE:      stage_en = in_valid & sof_in;
            FILL, RUN: stage_en = in_valid;
            FLUSH:     stage_en = 1'b1;
            default:   stage_en = 1'b0;
        endcase
        stage_en = stage_en & resetn;
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        fill_d       = fill_q;
        flush_d      = flush_q;
        flush_req_d  = flush_req_q;
        first_d      = first_q;
        rom_addr_d   = rom_addr_q;
        issue        = stage_en & ((state_q == RUN) | (state_q == FLUSH));
        if (stage_en) begin
            c_d        = c_q + 1'b1;
            rom_addr_d = k_ext * m_ext;
        end
        if ((state_q == FILL || state_q == RUN) && stop) flush_req_d = 1'b1;
        if (issue) first_d = 1'b0;
        case (state_q)
            IDLE: if (stage_en) begin
                state_d     = FILL;
                fill_d      = 1;
                flush_req_d = stop;
            end
            FILL: if (stage_en) begin
                fill_d = fill_q + 1'b1;
                if (fill_q == LAST_C) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end
            end
            RUN: if (stage_en && c_q == CMAX && flush_req_d) begin
                state_d     = FLUSH;
                flush_req_d = 1'b0;
                flush_d     = '0;
            end
            FLUSH: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == LAST_C) begin
                    state_d = IDLE;
                    c_d     = '0;
                    flush_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        vpipe_d[0] = issue;
        spipe_d[0] = issue & first_q & (state_q == RUN);
        lpipe_d[0] = issue & (state_q == FLUSH) & (flush_q == LAST_C);
        for (int i = 1; i < PIPE_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            spipe_d[i] = spipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
        frame_done_d = lpipe_q[PIPE_LAT-1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            c_q          <= '0;
            fill_q       <= '0;
            flush_q      <= '0;
            flush_req_q  <= 1'b0;
            first_q      <= 1'b0;
            rom_addr_q   <= '0;
            vpipe_q      <= '0;
            spipe_q      <= '0;
            lpipe_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            fill_q       <= fill_d;
            flush_q      <= flush_d;
            flush_req_q  <= flush_req_d;
            first_q      <= first_d;
            rom_addr_q   <= rom_addr_d;
            vpipe_q      <= vpipe_d;
            spipe_q      <= spipe_d;
            lpipe_q      <= lpipe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign zero_in    = (state_q == FLUSH);
    assign busy       = (state_q != IDLE);
    assign s1         = c_q[L-1];
    assign s2         = c_q[L-2];
    assign t          = c_q[L-1] & ~c_q[L-2];
    assign rom_addr   = rom_addr_q;
    assign out_valid  = vpipe_q[PIPE_LAT-1];
    assign sof_out    = spipe_q[PIPE_LAT-1];
    assign frame_done = frame_done_q;

`ifdef FFT_R22_STAGE_CTRL_STALLCNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && stage_en) stall_cnt_d = '0;
        else if ((state_q == FILL || state_q == RUN) && !in_valid && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fft_r22_stage_ctrl.sv
// tb/tb_fft_r22_stage_ctrl.sv - scoreboard bench for fft_r22_stage_ctrl
module tb_fft_r22_stage_ctrl;
    localparam int PIPE_LAT = 1;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0, sof_in = 1'b0, stop = 1'b0;
    logic       stage_en, zero_in, s1, s2, t, out_valid, sof_out, frame_done, busy;
    logic [5:0] rom_addr;
`ifdef FFT_R22_STAGE_CTRL_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {int j; bit sof;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0, checks = 0, out_cnt = 0, fd_cnt = 0;
    logic mon_en = 1'b0, issue_now = 1'b0, last_now = 1'b0;
    logic [PIPE_LAT:0] vhist = '0, lhist = '0;

    fft_r22_stage_ctrl #(.LOG2N(6), .ROM_LAT(1), .PIPE_LAT(PIPE_LAT)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .sof_in(sof_in), .stop(stop),
        .stage_en(stage_en), .zero_in(zero_in), .s1(s1), .s2(s2), .t(t), .rom_addr(rom_addr),
        .out_valid(out_valid), .sof_out(sof_out), .frame_done(frame_done), .busy(busy)
`ifdef FFT_R22_STAGE_CTRL_STALLCNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic int addr_of(input int j);
        case (j / 16)
            0:       return 0;
            1:       return 2 * (j % 16);
            2:       return j % 16;
            default: return 3 * (j % 16);
        endcase
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vhist <= '0;
            lhist <= '0;
        end else begin
            vhist <= {vhist[PIPE_LAT-1:0], issue_now};
            lhist <= {lhist[PIPE_LAT-1:0], last_now};
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (out_valid !== vhist[PIPE_LAT-1]) begin errors++; $display("FAIL out_valid_timing t=%0t got %b exp %b", $time, out_valid, vhist[PIPE_LAT-1]); end
            checks++;
            if (frame_done !== lhist[PIPE_LAT]) begin errors++; $display("FAIL frame_done t=%0t got %b exp %b", $time, frame_done, lhist[PIPE_LAT]); end
            if (frame_done === 1'b1) fd_cnt++;
            if (out_valid === 1'b1) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL scoreboard_empty t=%0t got out_valid exp none", $time); end
                else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (sof_out !== mon_e.sof) begin errors++; $display("FAIL sof_out j=%0d got %b exp %b", mon_e.j, sof_out, mon_e.sof); end
                end
            end else begin
                checks++;
                if (sof_out !== 1'b0) begin errors++; $display("FAIL sof_out_idle t=%0t got %b exp 0", $time, sof_out); end
            end
        end
    end

    task automatic test_reset;
        resetn = 0; in_valid = 1; sof_in = 1; stop = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({stage_en, zero_in, s1, s2, t, rom_addr, out_valid, sof_out, frame_done, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {stage_en, zero_in, s1, s2, t, rom_addr, out_valid, sof_out, frame_done, busy});
        end
        in_valid = 0; sof_in = 0; stop = 0;
        @(posedge clock); #1 resetn = 1; mon_en = 1;
        @(negedge clock);
        checks++;
        if ({stage_en, busy, rom_addr} !== '0) begin errors++; $display("FAIL post_reset got %h exp 0", {stage_en, busy, rom_addr}); end
        @(posedge clock); #1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i != 3); sof_in = 0; stop = (i >= 3);
            @(negedge clock);
            checks++; if (stage_en !== 1'b0) begin errors++; $display("FAIL idle_stage_en i=%0d got %b exp 0", i, stage_en); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy i=%0d got %b exp 0", i, busy); end
            @(posedge clock); #1;
        end
        in_valid = 0; stop = 0;
    endtask

    task automatic test_midreset;
        int c;
        exp_t e;
        for (int n = 0; n <= 84; n++) begin
            in_valid = 1; sof_in = (n == 0); stop = 0;
            issue_now = (n >= 48);
            if (n >= 48) begin e.j = n - 48; e.sof = (n == 48); exp_q.push_back(e); end
            c = n % 64;
            @(negedge clock);
            checks++; if (stage_en !== 1'b1) begin errors++; $display("FAIL mr_stage_en n=%0d got %b exp 1", n, stage_en); end
            checks++; if (zero_in !== 1'b0) begin errors++; $display("FAIL mr_zero_in n=%0d got %b exp 0", n, zero_in); end
            checks++; if (busy !== (n != 0)) begin errors++; $display("FAIL mr_busy n=%0d got %b exp %b", n, busy, n != 0); end
            checks++; if (s1 !== (c >= 32)) begin errors++; $display("FAIL mr_s1 c=%0d got %b", c, s1); end
            if (n >= 48) begin
                checks++;
                if (rom_addr !== 6'(addr_of((n - 48) % 64))) begin errors++; $display("FAIL mr_rom_addr n=%0d got %0d exp %0d", n, rom_addr, addr_of((n - 48) % 64)); end
            end
            if (n < 84) begin @(posedge clock); #1; end
        end
        #2 resetn = 0;
        #1;
        checks++;
        if ({stage_en, zero_in, s1, s2, t, rom_addr, out_valid, sof_out, frame_done, busy} !== '0) begin
            errors++; $display("FAIL async_reset got %h exp 0", {stage_en, zero_in, s1, s2, t, rom_addr, out_valid, sof_out, frame_done, busy});
        end
        issue_now = 0; in_valid = 0; sof_in = 0;
        exp_q.delete();
        @(posedge clock); #1 resetn = 1;
        for (int n = 0; n < 20; n++) begin
            in_valid = 1; sof_in = (n == 0);
            @(negedge clock);
            checks++; if (stage_en !== 1'b1) begin errors++; $display("FAIL restart_stage_en n=%0d got %b exp 1", n, stage_en); end
            checks++; if (busy !== (n != 0)) begin errors++; $display("FAIL restart_busy n=%0d got %b exp %b", n, busy, n != 0); end
            checks++; if (s2 !== (n >= 16)) begin errors++; $display("FAIL restart_s2 n=%0d got %b exp %b", n, s2, n >= 16); end
            @(posedge clock); #1;
        end
        in_valid = 0; sof_in = 0; resetn = 0;
        @(posedge clock); #1 resetn = 1;
    endtask

    task automatic test_stream(input int stall_period);
        int n, cyc, gaps, c, out0, fd0;
        logic iv, stop_sent;
        exp_t e;
        n = 0; cyc = 0; gaps = 0; stop_sent = 0;
        out0 = out_cnt; fd0 = fd_cnt;
        while (n < 64) begin
            iv = !(stall_period != 0 && n > 0 && (cyc % stall_period) == stall_period - 1);
            in_valid = iv; sof_in = (n == 0);
            stop = (!stop_sent && n == 10);
            if (stop) stop_sent = 1;
            issue_now = iv && (n >= 48);
            if (iv && n >= 48) begin e.j = n - 48; e.sof = (n == 48); exp_q.push_back(e); end
            c = n % 64;
            @(negedge clock);
            checks++; if (stage_en !== iv) begin errors++; $display("FAIL stage_en n=%0d got %b exp %b", n, stage_en, iv); end
            checks++; if (s1 !== (c >= 32)) begin errors++; $display("FAIL s1 c=%0d got %b", c, s1); end
            checks++; if (s2 !== ((c >= 16 && c < 32) || c >= 48)) begin errors++; $display("FAIL s2 c=%0d got %b", c, s2); end
            checks++; if (t !== (c >= 32 && c < 48)) begin errors++; $display("FAIL t c=%0d got %b", c, t); end
            checks++; if (zero_in !== 1'b0) begin errors++; $display("FAIL zero_in_run n=%0d got %b exp 0", n, zero_in); end
            checks++; if (busy !== (n != 0)) begin errors++; $display("FAIL busy_run n=%0d got %b exp %b", n, busy, n != 0); end
            if (n >= 48) begin
                checks++;
                if (rom_addr !== 6'(addr_of(n - 48))) begin errors++; $display("FAIL rom_addr j=%0d got %0d exp %0d", n - 48, rom_addr, addr_of(n - 48)); end
            end
            @(posedge clock); #1;
            if (iv) n++;
            else gaps++;
            cyc++;
        end
        in_valid = 0; sof_in = 0; stop = 0;
        for (int f = 0; f < 48; f++) begin
            issue_now = 1; last_now = (f == 47);
            e.j = 16 + f; e.sof = 0; exp_q.push_back(e);
            @(negedge clock);
            checks++; if ({stage_en, zero_in, busy} !== 3'b111) begin errors++; $display("FAIL flush_ctrl f=%0d got %b exp 111", f, {stage_en, zero_in, busy}); end
            checks++; if ({s1, s2, t} !== {f >= 32, (f >= 16 && f < 32), (f >= 32)}) begin errors++; $display("FAIL flush_sel f=%0d got %b", f, {s1, s2, t}); end
            checks++; if (rom_addr !== 6'(addr_of(16 + f))) begin errors++; $display("FAIL flush_rom j=%0d got %0d exp %0d", 16 + f, rom_addr, addr_of(16 + f)); end
            @(posedge clock); #1;
        end
        issue_now = 0; last_now = 0;
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock);
        checks++; if (out_cnt - out0 !== 64) begin errors++; $display("FAIL out_count got %0d exp 64", out_cnt - out0); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", fd_cnt - fd0); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        checks++; if ({busy, zero_in, stage_en} !== 3'b000) begin errors++; $display("FAIL end_idle got %b exp 000", {busy, zero_in, stage_en}); end
`ifdef FFT_R22_STAGE_CTRL_STALLCNT_EN
        checks++; if (stall_cnt !== 16'(gaps)) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, gaps); end
`endif
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset;
        test_idle;
        test_midreset;
        test_stream(0);
        test_stream(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
